// File: rtl/crop_window_ctrl.sv
// Frame-geometry lock controller and double-buffered crop window for the crop/fill stage.
// Optional lock-loss interrupt enabled by defining CROP_WIN_IRQ_EN.
module crop_window_ctrl #(
    parameter int CNT_BITS      = 12,
    parameter int TOTAL_ROWS    = 720,
    parameter int TOTAL_COLS    = 1280,
    parameter int LOCK_FRAMES   = 2,
    parameter int DEF_SKIP_COLS = 2,
    parameter int DEF_SKIP_ROWS = 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                vs_i,
    input  logic                de_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [CNT_BITS-1:0] cfg_skip_cols_i,
    input  logic [CNT_BITS-1:0] cfg_skip_rows_i,
    output logic                cfg_err_o,
    output logic                skip_o,
    output logic                locked_o,
    output logic [7:0]          err_cnt_o,
    output logic [CNT_BITS-1:0] meas_cols_o,
    output logic [CNT_BITS-1:0] meas_rows_o,
    output logic                irq_o,
    input  logic                irq_clr_i
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_ERR     = 2'd3;

    localparam int MW = $clog2(LOCK_FRAMES + 1);
    localparam int XW = CNT_BITS + 1;
    localparam logic [XW-1:0]       COLS_X  = XW'(TOTAL_COLS);
    localparam logic [XW-1:0]       ROWS_X  = XW'(TOTAL_ROWS);
    localparam logic [CNT_BITS-1:0] COLS_N  = CNT_BITS'(TOTAL_COLS);
    localparam logic [CNT_BITS-1:0] ROWS_N  = CNT_BITS'(TOTAL_ROWS);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [MW-1:0]       LOCK_N  = MW'(LOCK_FRAMES);
    localparam logic                LOCK_ONE = (LOCK_FRAMES == 1);

    logic                vs_q, de_q;
    logic                fb, de_fall;
    logic [CNT_BITS-1:0] col_cnt, row_cnt;
    logic                line_bad, frame_ok;
    logic [1:0]          state;
    logic [MW-1:0]       match_cnt, match_inc;
    logic [CNT_BITS-1:0] act_cols, act_rows, pend_cols, pend_rows;
    logic                cfg_xfer, cfg_bad;
    logic [XW-1:0]       col_x, row_x, sc_x, sr_x;
    logic                skip_nxt;

    assign fb        = vs_i & ~vs_q;
    assign de_fall   = ~de_i & de_q;
    // line_bad and row_cnt here are the pre-clear values of the frame just ended
    assign frame_ok  = (row_cnt == ROWS_N) && !line_bad;
    assign match_inc = match_cnt + MW'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            col_cnt     <= '0;
            row_cnt     <= '0;
            line_bad    <= 1'b0;
            meas_cols_o <= '0;
            meas_rows_o <= '0;
        end else begin
            vs_q <= vs_i;
            de_q <= de_i;
            if (!de_i)
                col_cnt <= '0;
            else if (col_cnt != CNT_MAX)
                col_cnt <= col_cnt + CNT_BITS'(1);
            if (fb)
                row_cnt <= '0;
            else if (de_fall && row_cnt != CNT_MAX)
                row_cnt <= row_cnt + CNT_BITS'(1);
            if (de_fall)
                meas_cols_o <= col_cnt;
            if (fb) begin
                meas_rows_o <= row_cnt;
                line_bad    <= 1'b0;
            end else if (de_fall && col_cnt != COLS_N) begin
                line_bad    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state     <= ST_IDLE;
            match_cnt <= '0;
            locked_o  <= 1'b0;
            err_cnt_o <= '0;
        end else if (fb) begin
            case (state)
                ST_IDLE: begin
                    state     <= ST_MEASURE;
                    match_cnt <= '0;
                end
                ST_MEASURE: begin
                    if (frame_ok) begin
                        match_cnt <= match_inc;
                        if (match_inc == LOCK_N) begin
                            state    <= ST_LOCKED;
                            locked_o <= 1'b1;
                        end
                    end else begin
                        match_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (!frame_ok) begin
                        state    <= ST_ERR;
                        locked_o <= 1'b0;
                        if (err_cnt_o != 8'hFF)
                            err_cnt_o <= err_cnt_o + 8'd1;
                    end
                end
                default: begin
                    state     <= (frame_ok && LOCK_ONE) ? ST_LOCKED : ST_MEASURE;
                    locked_o  <= frame_ok && LOCK_ONE;
                    match_cnt <= frame_ok ? MW'(1) : '0;
                end
            endcase
        end
    end

    // A window is pending exactly while cfg_ready_o is low
    assign cfg_xfer = cfg_valid_i && cfg_ready_o;
    assign cfg_bad  = ({cfg_skip_cols_i, 1'b0} >= COLS_X) || ({cfg_skip_rows_i, 1'b0} >= ROWS_X);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            act_cols    <= CNT_BITS'(DEF_SKIP_COLS);
            act_rows    <= CNT_BITS'(DEF_SKIP_ROWS);
            pend_cols   <= '0;
            pend_rows   <= '0;
            cfg_ready_o <= 1'b1;
            cfg_err_o   <= 1'b0;
        end else begin
            cfg_err_o <= cfg_xfer && cfg_bad;
            if (fb && !cfg_ready_o) begin
                act_cols <= pend_cols;
                act_rows <= pend_rows;
            end
            if (cfg_xfer && !cfg_bad) begin
                pend_cols   <= cfg_skip_cols_i;
                pend_rows   <= cfg_skip_rows_i;
                cfg_ready_o <= 1'b0;
            end else if (fb) begin
                cfg_ready_o <= 1'b1;
            end
        end
    end

    assign col_x = {1'b0, col_cnt};
    assign row_x = {1'b0, row_cnt};
    assign sc_x  = {1'b0, act_cols};
    assign sr_x  = {1'b0, act_rows};
    assign skip_nxt = de_i && (!locked_o || col_x < sc_x || col_x >= COLS_X - sc_x ||
                               row_x < sr_x || row_x >= ROWS_X - sr_x);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            skip_o <= 1'b0;
        else
            skip_o <= skip_nxt;
    end

`ifdef CROP_WIN_IRQ_EN
    logic lock_loss;
    assign lock_loss = fb && (state == ST_LOCKED) && !frame_ok;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            irq_o <= 1'b0;
        else if (lock_loss)
            irq_o <= 1'b1;
        else if (irq_clr_i)
            irq_o <= 1'b0;
    end
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr_i;
    assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_crop_window_ctrl.sv
// Self-checking bench for crop_window_ctrl on a reduced 6x10 frame geometry.
module tb_crop_window_ctrl;
    localparam int R  = 6;
    localparam int C  = 10;
    localparam int LF = 2;
`ifdef CROP_WIN_IRQ_EN
    localparam int IRQ_EXP = 1;
`else
    localparam int IRQ_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n_i, vs_i, de_i, cfg_valid_i, irq_clr_i;
    logic [11:0] cfg_skip_cols_i, cfg_skip_rows_i;
    logic        cfg_ready_o, cfg_err_o, skip_o, locked_o, irq_o;
    logic [7:0]  err_cnt_o;
    logic [11:0] meas_cols_o, meas_rows_o;

    always #5 clk = ~clk;

    crop_window_ctrl #(
        .CNT_BITS(12), .TOTAL_ROWS(R), .TOTAL_COLS(C), .LOCK_FRAMES(LF),
        .DEF_SKIP_COLS(2), .DEF_SKIP_ROWS(2)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .vs_i(vs_i), .de_i(de_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_skip_cols_i(cfg_skip_cols_i), .cfg_skip_rows_i(cfg_skip_rows_i),
        .cfg_err_o(cfg_err_o), .skip_o(skip_o), .locked_o(locked_o),
        .err_cnt_o(err_cnt_o), .meas_cols_o(meas_cols_o), .meas_rows_o(meas_rows_o),
        .irq_o(irq_o), .irq_clr_i(irq_clr_i)
    );

    int n_cmp = 0, n_fail = 0;

    // reference model: expected outputs after the coming clock edge
    int m_skip, m_locked, m_err, m_ready, m_cfg_err, m_mcols, m_mrows, m_irq;
    int m_sc, m_sr, m_pc, m_pr, m_run, m_seen_fb;
    int m_col, m_rows, m_bad, m_vs_prev, m_de_prev;
    int m_pix_vld, m_pix_r, m_pix_c;

    int g_cyc = 0, g_cfg_at = -1, g_cc = 0, g_cr = 0, g_clr = 0, g_rst = 0;
    int obs_locked, obs_err, obs_mrows;
    int cap [0:15][0:15];

    typedef struct {
        int rows; int bad_line; int bad_len; int cfg_at; int cc; int cr;
        int e_locked; int e_err; int e_mrows;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_skip = 0; m_locked = 0; m_err = 0; m_ready = 1; m_cfg_err = 0;
        m_mcols = 0; m_mrows = 0; m_irq = 0;
        m_sc = 2; m_sr = 2; m_pc = 0; m_pr = 0; m_run = 0; m_seen_fb = 0;
        m_col = 0; m_rows = 0; m_bad = 0; m_vs_prev = 0; m_de_prev = 0;
        m_pix_vld = 0; m_pix_r = 0; m_pix_c = 0;
    endtask

    task automatic model_adv();
        bit fb, fall, xfer, ok, loss;
        fb   = vs_i && !m_vs_prev;
        fall = !de_i && m_de_prev;
        xfer = cfg_valid_i && (m_ready != 0);
        loss = 0;
        m_pix_vld = de_i; m_pix_r = m_rows; m_pix_c = m_col;
        m_skip = de_i && (!m_locked || m_col < m_sc || m_col >= C - m_sc ||
                          m_rows < m_sr || m_rows >= R - m_sr);
        if (fall) begin
            m_mcols = m_col;
            if (m_col != C) m_bad = 1;
            m_rows++;
        end
        if (fb) begin
            ok = (m_rows == R) && !m_bad;
            m_mrows = m_rows; m_rows = 0; m_bad = 0;
            if (m_seen_fb) begin
                if (ok) begin
                    m_run++;
                    if (m_run >= LF) m_locked = 1;
                end else begin
                    if (m_locked) begin
                        loss = 1;
                        if (m_err < 255) m_err++;
                    end
                    m_locked = 0; m_run = 0;
                end
            end
            m_seen_fb = 1;
            if (!m_ready) begin m_sc = m_pc; m_sr = m_pr; m_ready = 1; end
        end
        m_cfg_err = 0;
        if (xfer) begin
            if (2 * int'(cfg_skip_cols_i) >= C || 2 * int'(cfg_skip_rows_i) >= R) m_cfg_err = 1;
            else begin m_pc = cfg_skip_cols_i; m_pr = cfg_skip_rows_i; m_ready = 0; end
        end
        m_col = de_i ? m_col + 1 : 0;
`ifdef CROP_WIN_IRQ_EN
        if (loss) m_irq = 1;
        else if (irq_clr_i) m_irq = 0;
`endif
        m_vs_prev = vs_i; m_de_prev = de_i;
    endtask

    task automatic step(input logic v, input logic d);
        @(negedge clk);
        chk("skip", skip_o, m_skip);
        chk("locked", locked_o, m_locked);
        chk("err_cnt", err_cnt_o, m_err);
        chk("cfg_ready", cfg_ready_o, m_ready);
        chk("cfg_err", cfg_err_o, m_cfg_err);
        chk("meas_cols", meas_cols_o, m_mcols);
        chk("meas_rows", meas_rows_o, m_mrows);
        chk("irq", irq_o, m_irq);
        if (m_pix_vld && m_pix_r < 16 && m_pix_c < 16) cap[m_pix_r][m_pix_c] = skip_o;
        if (g_cyc == 1) begin obs_locked = locked_o; obs_err = err_cnt_o; obs_mrows = meas_rows_o; end
        vs_i = v; de_i = d;
        if (g_cyc == g_cfg_at) begin
            cfg_valid_i = 1'b1; cfg_skip_cols_i = 12'(g_cc); cfg_skip_rows_i = 12'(g_cr);
        end else begin
            cfg_valid_i = 1'b0;
        end
        irq_clr_i = (g_clr != 0); g_clr = 0;
        rst_n_i = (g_rst == 0);
        g_cyc++;
        if (g_rst != 0) begin model_reset(); g_rst = 0; end
        else model_adv();
    endtask

    task automatic frame(input int rows, input int bad_line, input int bad_len,
                         input int cfg_at, input int cc, input int cr);
        g_cyc = 0; g_cfg_at = cfg_at; g_cc = cc; g_cr = cr;
        step(1'b1, 1'b0);
        for (int r = 0; r < rows; r++) begin
            int len;
            len = (r == bad_line) ? bad_len : C;
            for (int c = 0; c < len; c++) step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
        g_cfg_at = -1;
    endtask

    task automatic ok_frame();
        frame(R, -1, 0, -1, 0, 0);
    endtask

    initial begin
        rst_n_i = 1'b0; vs_i = 1'b0; de_i = 1'b0; cfg_valid_i = 1'b0; irq_clr_i = 1'b0;
        cfg_skip_cols_i = '0; cfg_skip_rows_i = '0;
        model_reset();

        tbl[0]  = '{6, -1, 0, -1, 0, 0, 0, 0, 0};
        tbl[1]  = '{6, -1, 0, -1, 0, 0, 0, 0, 6};
        tbl[2]  = '{6, -1, 0, -1, 0, 0, 1, 0, 6};
        tbl[3]  = '{5, -1, 0, -1, 0, 0, 1, 0, 6};
        tbl[4]  = '{6, -1, 0, -1, 0, 0, 0, 1, 5};
        tbl[5]  = '{6, -1, 0, -1, 0, 0, 0, 1, 6};
        tbl[6]  = '{6,  3, 9, -1, 0, 0, 1, 1, 6};
        tbl[7]  = '{6, -1, 0, -1, 0, 0, 0, 2, 6};
        tbl[8]  = '{6,  1, 9, -1, 0, 0, 0, 2, 6};
        tbl[9]  = '{6, -1, 0, -1, 0, 0, 0, 2, 6};
        tbl[10] = '{6, -1, 0, -1, 0, 0, 0, 2, 6};
        tbl[11] = '{6, -1, 0,  5, 5, 2, 1, 2, 6};
        tbl[12] = '{6, -1, 0,  8, 3, 2, 1, 2, 6};
        tbl[13] = '{6, -1, 0, -1, 0, 0, 1, 2, 6};

        g_rst = 1; step(1'b0, 1'b0);
        g_rst = 1; step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("reset_ready", cfg_ready_o, 1);
        chk("reset_locked", locked_o, 0);

        for (int i = 0; i < 14; i++) begin
            frame(tbl[i].rows, tbl[i].bad_line, tbl[i].bad_len, tbl[i].cfg_at, tbl[i].cc, tbl[i].cr);
            chk($sformatf("vec%0d_locked", i), obs_locked, tbl[i].e_locked);
            chk($sformatf("vec%0d_err", i), obs_err, tbl[i].e_err);
            chk($sformatf("vec%0d_mrows", i), obs_mrows, tbl[i].e_mrows);
            if (i == 1) chk("unlocked_fill", cap[2][4], 1);
            if (i == 2) begin
                chk("def_c0", cap[2][0], 1); chk("def_c1", cap[2][1], 1);
                chk("def_c8", cap[2][8], 1); chk("def_c9", cap[2][9], 1);
                chk("def_r0", cap[0][4], 1); chk("def_r1", cap[1][4], 1);
                chk("def_r4", cap[4][4], 1); chk("def_r5", cap[5][4], 1);
                chk("def_r2c2", cap[2][2], 0); chk("def_r3c7", cap[3][7], 0);
            end
            if (i == 12) chk("pend_not_mid", cap[2][2], 0);
            if (i == 13) begin
                chk("new_c2", cap[2][2], 1); chk("new_c3", cap[2][3], 0);
                chk("new_c6", cap[2][6], 0); chk("new_c7", cap[2][7], 1);
            end
        end

        // window offered in the frame-boundary cycle waits one more frame
        frame(R, -1, 0, 0, 1, 1);
        chk("fbcfg_old_win", cap[2][2], 1);
        ok_frame();
        chk("fbcfg_new_r1c1", cap[1][1], 0);
        chk("fbcfg_new_r0c1", cap[0][1], 1);

        // lock loss and interrupt clear
        frame(5, -1, 0, -1, 0, 0);
        ok_frame();
        chk("loss_locked", obs_locked, 0);
        chk("loss_irq", irq_o, IRQ_EXP);
        g_clr = 1; step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("irq_cleared", irq_o, 0);

        // reset in the middle of a line
        g_cyc = 0; step(1'b1, 1'b0);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b1);
        g_rst = 1; step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("midrst_skip", skip_o, 0);
        chk("midrst_locked", locked_o, 0);
        chk("midrst_err", err_cnt_o, 0);
        chk("midrst_ready", cfg_ready_o, 1);
        chk("midrst_mcols", meas_cols_o, 0);
        ok_frame();
        ok_frame();
        chk("relock_fb2", obs_locked, 0);
        ok_frame();
        chk("relock_fb3", obs_locked, 1);

        for (int i = 0; i < 40; i++) begin
            int rows, bl, blen, cat;
            rows = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 7)) : R;
            bl   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, rows - 1)) : -1;
            blen = $urandom_range(1, C + 1);
            cat  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1;
            frame(rows, bl, blen, cat, $urandom_range(0, 6), $urandom_range(0, 4));
        end

        // repeated lock losses saturate the counter
        ok_frame(); ok_frame(); ok_frame();
        for (int i = 0; i < 258; i++) begin
            frame(5, -1, 0, -1, 0, 0);
            ok_frame();
            ok_frame();
        end
        frame(5, -1, 0, -1, 0, 0);
        step(1'b0, 1'b0);
        chk("err_sat", err_cnt_o, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
